// File: rtl/game_timer_pkg.sv
// Shared types and helpers for the match clock.
// Holds the FSM state enum, the BCD digit type, the packed MM:SS digit triple
// and the BCD countdown helper. The display decoder and the game FSM import
// the same digit type.
package game_timer_pkg;

    localparam int unsigned BCD_W = 4;

    typedef logic [BCD_W-1:0] bcd_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSED  = 2'd2,
        EXPIRED = 2'd3
    } state_e;

    // Packed MM:SS digit triple, minute digit in the top nibble.
    typedef struct packed {
        bcd_t mins;
        bcd_t tens;
        bcd_t ones;
    } mmss_t;

    localparam bcd_t SEC_TENS_MAX = 4'd5;
    localparam bcd_t DIGIT_MAX    = 4'd9;

    // One-second BCD countdown, digit by digit with borrow into the next digit.
    function automatic mmss_t mmss_dec(input mmss_t v);
        mmss_t r;
        r = v;
        if (v.ones != '0) begin
            r.ones = v.ones - 4'd1;
        end else begin
            r.ones = DIGIT_MAX;
            if (v.tens != '0) begin
                r.tens = v.tens - 4'd1;
            end else begin
                r.tens = SEC_TENS_MAX;
                r.mins = v.mins - 4'd1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/game_timer_tick.sv
// tick_gen: one-second prescaler for the match clock.
// Ports: clk, rst (sync, active-high), clr (zero the count), en (advance the
// count), tick (high for the cycle in which an enabled count sits at terminal
// count; the count wraps to 0 on that edge).
// With en low the count holds, so a partial second survives a pause, and a
// count frozen at terminal count produces its tick on the first enabled cycle.
module tick_gen #(
    parameter int unsigned CLK_FREQ_HZ = 50000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int unsigned CNT_W = (CLK_FREQ_HZ > 1) ? $clog2(CLK_FREQ_HZ) : 1;
    localparam logic [CNT_W-1:0] TC = CNT_W'(CLK_FREQ_HZ - 1);

    logic [CNT_W-1:0] count_q, count_d;

    assign tick = en && (count_q == TC);

    // Next count: clear wins over enable; wrap at terminal count.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = (count_q == TC) ? '0 : count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/game_timer.sv
// game_timer: MM:SS BCD countdown match clock for the Pong game.
// Ports: clk, rst (sync, active-high); start/pause/load command pulses
// (priority rst > load > pause > start); min/sec_tens/sec_ones BCD digits;
// running/expired state decodes; done one-cycle pulse on reaching 00:00;
// warn low-time flag.
// Optional feature macro GAME_TIMER_WARN_EN: when defined, warn is high in
// RUN/PAUSED during the last 9 seconds and in EXPIRED; otherwise warn is 0.
module game_timer
    import game_timer_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 50000000,
    parameter int unsigned START_MIN   = 3,
    parameter int unsigned START_SEC   = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       pause,
    input  logic       load,
    output logic [3:0] min,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running,
    output logic       expired,
    output logic       done,
    output logic       warn
);

    localparam mmss_t PRESET = '{
        mins: BCD_W'(START_MIN),
        tens: BCD_W'(START_SEC / 10),
        ones: BCD_W'(START_SEC % 10)
    };
    localparam logic PRESET_ZERO = (PRESET == '0);

    state_e state_q, state_d;
    mmss_t  digits_q, digits_d;
    mmss_t  digits_dec;
    logic   running_q, running_d;
    logic   expired_q, expired_d;
    logic   done_q, done_d;
    logic   tg_clr, tg_en, tick;

    tick_gen #(
        .CLK_FREQ_HZ(CLK_FREQ_HZ)
    ) u_tick_gen (
        .clk (clk),
        .rst (rst),
        .clr (tg_clr),
        .en  (tg_en),
        .tick(tick)
    );

    assign digits_dec = mmss_dec(digits_q);

    // Next state, digits and prescaler control.
    always_comb begin
        state_d  = state_q;
        digits_d = digits_q;
        done_d   = 1'b0;
        tg_clr   = 1'b0;
        tg_en    = 1'b0;
        if (load) begin
            state_d  = IDLE;
            digits_d = PRESET;
            tg_clr   = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        tg_clr = 1'b1;
                        // A 00:00 preset has nothing to count: expire at once.
                        if (PRESET_ZERO) begin
                            state_d = EXPIRED;
                            done_d  = 1'b1;
                        end else begin
                            state_d = RUN;
                        end
                    end
                end
                RUN: begin
                    // Pause freezes the prescaler even at terminal count.
                    if (pause) begin
                        state_d = PAUSED;
                    end else begin
                        tg_en = 1'b1;
                        if (tick) begin
                            digits_d = digits_dec;
                            if (digits_dec == '0) begin
                                state_d = EXPIRED;
                                done_d  = 1'b1;
                            end
                        end
                    end
                end
                PAUSED: begin
                    if (start) begin
                        state_d = RUN;
                    end
                end
                EXPIRED: begin
                    state_d = EXPIRED;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
        running_d = (state_d == RUN);
        expired_d = (state_d == EXPIRED);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            digits_q  <= PRESET;
            running_q <= 1'b0;
            expired_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            digits_q  <= digits_d;
            running_q <= running_d;
            expired_q <= expired_d;
            done_q    <= done_d;
        end
    end

`ifdef GAME_TIMER_WARN_EN
    logic warn_q, warn_d;

    // Low-time flag tracks the next digits so it changes on the same edge.
    always_comb begin
        warn_d = ((state_d == RUN) || (state_d == PAUSED)) &&
                 (digits_d.mins == '0) && (digits_d.tens == '0);
        if (state_d == EXPIRED) begin
            warn_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            warn_q <= 1'b0;
        end else begin
            warn_q <= warn_d;
        end
    end

    assign warn = warn_q;
`else
    assign warn = 1'b0;
`endif

    assign min      = digits_q.mins;
    assign sec_tens = digits_q.tens;
    assign sec_ones = digits_q.ones;
    assign running  = running_q;
    assign expired  = expired_q;
    assign done     = done_q;

endmodule

// File: tb/tb_game_timer.sv
// Self-checking bench for game_timer: four instances with different presets
// (1:05, 0:02, 0:12, 0:00) share one command stream. A seconds-remaining model
// predicts every output each cycle; directed steps pin known values.
module tb_game_timer;

    localparam int unsigned F = 4;
    localparam int unsigned N = 4;
    localparam int unsigned PRESET [N] = '{65, 2, 12, 0};

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_PAUS = 2;
    localparam int M_EXP  = 3;

    logic clk = 1'b0;
    logic rst_i = 1'b1, start_i = 1'b0, pause_i = 1'b0, load_i = 1'b0;

    logic [3:0] min_w [N];
    logic [3:0] tens_w [N];
    logic [3:0] ones_w [N];
    logic       run_w [N];
    logic       exp_w [N];
    logic       done_w [N];
    logic       warn_w [N];

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    int m_mode [N];
    int m_secs [N];
    int m_phase [N];
    bit m_done [N];

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        game_timer #(
            .CLK_FREQ_HZ(F),
            .START_MIN  (PRESET[g] / 60),
            .START_SEC  (PRESET[g] % 60)
        ) u_dut (
            .clk     (clk),
            .rst     (rst_i),
            .start   (start_i),
            .pause   (pause_i),
            .load    (load_i),
            .min     (min_w[g]),
            .sec_tens(tens_w[g]),
            .sec_ones(ones_w[g]),
            .running (run_w[g]),
            .expired (exp_w[g]),
            .done    (done_w[g]),
            .warn    (warn_w[g])
        );
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    // Behavioural model: whole seconds remaining plus cycles into the current second.
    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            m_done[i] = 1'b0;
            if (rst_i || load_i) begin
                m_mode[i]  = M_IDLE;
                m_secs[i]  = int'(PRESET[i]);
                m_phase[i] = 0;
            end else if (m_mode[i] == M_IDLE) begin
                if (start_i) begin
                    m_phase[i] = 0;
                    if (PRESET[i] == 0) begin
                        m_mode[i] = M_EXP;
                        m_done[i] = 1'b1;
                    end else begin
                        m_mode[i] = M_RUN;
                    end
                end
            end else if (m_mode[i] == M_RUN) begin
                if (pause_i) begin
                    m_mode[i] = M_PAUS;
                end else if (m_phase[i] == int'(F) - 1) begin
                    m_phase[i] = 0;
                    m_secs[i]  = m_secs[i] - 1;
                    if (m_secs[i] == 0) begin
                        m_mode[i] = M_EXP;
                        m_done[i] = 1'b1;
                    end
                end else begin
                    m_phase[i] = m_phase[i] + 1;
                end
            end else if (m_mode[i] == M_PAUS) begin
                if (start_i) m_mode[i] = M_RUN;
            end
        end
    end

    function automatic int exp_warn(input int i);
`ifdef GAME_TIMER_WARN_EN
        return int'((((m_mode[i] == M_RUN) || (m_mode[i] == M_PAUS)) && (m_secs[i] < 10))
                    || (m_mode[i] == M_EXP));
`else
        return 0;
`endif
    endfunction

    // Per-cycle comparison of every instance against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < N; i++) begin
                chk($sformatf("u%0d_min", i), int'(min_w[i]), m_secs[i] / 60);
                chk($sformatf("u%0d_tens", i), int'(tens_w[i]), (m_secs[i] % 60) / 10);
                chk($sformatf("u%0d_ones", i), int'(ones_w[i]), m_secs[i] % 10);
                chk($sformatf("u%0d_running", i), int'(run_w[i]), int'(m_mode[i] == M_RUN));
                chk($sformatf("u%0d_expired", i), int'(exp_w[i]), int'(m_mode[i] == M_EXP));
                chk($sformatf("u%0d_done", i), int'(done_w[i]), int'(m_done[i]));
                chk($sformatf("u%0d_warn", i), int'(warn_w[i]), exp_warn(i));
            end
        end
    end

    // Apply one cycle of commands, return 2 time units after the sampling edge.
    task automatic step(input logic r, input logic l, input logic p, input logic s);
        rst_i   = r;
        load_i  = l;
        pause_i = p;
        start_i = s;
        @(posedge clk);
        #2;
        rst_i   = 1'b0;
        load_i  = 1'b0;
        pause_i = 1'b0;
        start_i = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic chk_digits(input string nm, input int i, input int mm, input int tt, input int oo);
        chk({nm, "_min"}, int'(min_w[i]), mm);
        chk({nm, "_tens"}, int'(tens_w[i]), tt);
        chk({nm, "_ones"}, int'(ones_w[i]), oo);
    endtask

    localparam int WARN_ON = `ifdef GAME_TIMER_WARN_EN 1 `else 0 `endif;

    initial begin
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk_en = 1'b1;
        chk_digits("rst_d0", 0, 1, 0, 5);
        chk("rst_running", int'(run_w[0]), 0);
        chk("rst_expired", int'(exp_w[0]), 0);
        chk("rst_done", int'(done_w[0]), 0);
        chk("rst_warn", int'(warn_w[2]), 0);

        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("start_running", int'(run_w[0]), 1);
        chk("zero_preset_done", int'(done_w[3]), 1);
        chk("zero_preset_expired", int'(exp_w[3]), 1);
        idle(3);
        chk_digits("pre_tick_d0", 0, 1, 0, 5);
        idle(1);
        chk_digits("first_tick_d0", 0, 1, 0, 4);
        chk_digits("first_tick_d1", 1, 0, 0, 1);
        idle(4);
        chk_digits("expire_d1", 1, 0, 0, 0);
        chk("expire_done", int'(done_w[1]), 1);
        chk("expire_flag", int'(exp_w[1]), 1);
        idle(1);
        chk("done_one_cycle", int'(done_w[1]), 0);
        idle(11);
        chk_digits("twenty_d0", 0, 1, 0, 0);
        chk_digits("hold_zero_d1", 1, 0, 0, 0);
        idle(4);
        chk_digits("min_borrow_d0", 0, 0, 5, 9);

        idle(2);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("paused_running", int'(run_w[0]), 0);
        idle(10);
        chk_digits("paused_hold_d0", 0, 0, 5, 9);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        idle(1);
        chk_digits("resume_partial_d0", 0, 0, 5, 9);
        idle(1);
        chk_digits("resume_tick_d0", 0, 0, 5, 8);

        step(1'b0, 1'b0, 1'b1, 1'b1);
        chk("pause_beats_start", int'(run_w[0]), 0);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        chk("load_beats_start", int'(exp_w[1]), 0);
        chk_digits("load_d0", 0, 1, 0, 5);
        chk_digits("load_d1", 1, 0, 0, 2);

        step(1'b0, 1'b0, 1'b0, 1'b1);
        idle(8);
        chk_digits("warn_ten_d2", 2, 0, 1, 0);
        chk("warn_at_ten", int'(warn_w[2]), 0);
        idle(4);
        chk_digits("warn_nine_d2", 2, 0, 0, 9);
        chk("warn_at_nine", int'(warn_w[2]), WARN_ON);
        idle(36);
        chk("warn_exp_flag", int'(exp_w[2]), 1);
        chk("warn_in_expired", int'(warn_w[2]), WARN_ON);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("warn_after_load", int'(warn_w[2]), 0);

        for (int c = 0; c < 4000; c++) begin
            step(1'($urandom_range(0, 299) == 0),
                 1'($urandom_range(0, 79) == 0),
                 1'($urandom_range(0, 11) == 0),
                 1'($urandom_range(0, 5) == 0));
        end

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/game_timer.md
Name: game_timer

Overview:
- Match-clock generator for the Pong game.
- Counts down from a preset MM:SS value in BCD.
- Drives the minute, seconds-tens and seconds-ones digits consumed by the seven-segment display decoder.
- Provides start/pause/load control and a one-cycle end-of-match pulse for the game FSM.

Parameters:
- CLK_FREQ_HZ, 50000000, clk cycles per one-second tick; legal range >=1 (bench uses 4).
- START_MIN, 3, preset minute digit; legal range 0..9.
- START_SEC, 0, preset seconds; legal range 0..59; split into tens/ones at elaboration.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  single-cycle pulse: begin or resume counting
- pause  in  1  single-cycle pulse: freeze counting
- load  in  1  single-cycle pulse: return to the preset value and IDLE
- min  out  4  BCD minute digit, range 0..9
- sec_tens  out  4  BCD seconds tens digit, range 0..5
- sec_ones  out  4  BCD seconds ones digit, range 0..9
- running  out  1  high while in state RUN
- expired  out  1  high while in state EXPIRED
- done  out  1  one-cycle pulse when the count reaches 00:00
- warn  out  1  low-time flag (see Optional Feature)

Behaviour:
- Clocking and reset:
  - Single clock domain: clk.
  - rst is synchronous, active-high.
  - All outputs are registered.
- Reset values:
  - state=IDLE, prescaler=0.
  - min/sec_tens/sec_ones = preset.
  - running=0, expired=0, done=0, warn=0.
- States: IDLE, RUN, PAUSED, EXPIRED.
- Command priority within a cycle: rst > load > pause > start.
- load in any state:
  - Next state IDLE, digits set to preset, prescaler=0, done=0.
  - Takes effect on the next edge.
- start:
  - From IDLE: go to RUN, prescaler=0.
  - From PAUSED: go to RUN, prescaler retained, so a partial second is preserved.
  - Ignored in RUN and EXPIRED.
- pause:
  - In RUN: go to PAUSED; digits and prescaler are frozen.
  - Ignored in all other states.
- Prescaler and decrement:
  - In RUN the prescaler counts 0..CLK_FREQ_HZ-1.
  - At terminal count it wraps to 0 and the digits decrement once.
  - The first decrement occurs CLK_FREQ_HZ cycles after the start edge.
- Decrement rules (BCD, no binary arithmetic on the digit triple):
  - sec_ones>0: sec_ones-1.
  - Otherwise sec_ones=9 and:
    - if sec_tens>0: sec_tens-1;
    - otherwise sec_tens=5 and min-1.
- Expiry:
  - A decrement yielding 00:00 moves to EXPIRED in the same edge.
  - done=1 for exactly that one cycle.
  - expired=1 from the same edge onward.
  - Digits hold at 00:00 in EXPIRED; no wrap to 9:59 ever.
- Zero preset:
  - If the preset is 00:00, start from IDLE goes directly to EXPIRED on the next edge with a done pulse.
  - No prescaler wait.
- Pause on a terminal-count cycle:
  - pause in the same cycle as prescaler terminal count wins.
  - No decrement; prescaler holds at terminal count.
  - After resume, the decrement happens on the first RUN cycle.
- rst mid-count: identical to power-on reset; any pending done is suppressed.
- Output derivation: running and expired are state decodes, registered alongside the state.

Optional Feature:
- Macro: GAME_TIMER_WARN_EN.
- When defined:
  - warn=1 while state is RUN or PAUSED and min==0 and sec_tens==0 (last 9 seconds).
  - warn=1 also in EXPIRED.
  - warn=0 in IDLE.
  - warn is registered and updates in the same edge as the digits.
- When undefined:
  - warn is tied to 0.
  - No comparison logic is generated.
  - The port remains present, so the top level is unchanged.

Decomposition:
- Shared package game_timer_pkg holds:
  - the state enum (IDLE, RUN, PAUSED, EXPIRED);
  - the 4-bit BCD digit typedef;
  - constants SEC_TENS_MAX=5 and DIGIT_MAX=9.
- The display decoder and the game FSM share the digit typedef from this package.
- One sub-module, tick_gen:
  - parameter CLK_FREQ_HZ;
  - inputs clk, rst, clr, en;
  - output tick, one cycle at terminal count;
  - holds count when en=0; clr zeroes it.
- game_timer instantiates tick_gen and keeps the FSM plus the BCD decrement logic.

Test Plan (CLK_FREQ_HZ=4, START_MIN=1, START_SEC=5 unless noted):
- rst, then start at cycle 0 -> digits 1:05 until the edge at cycle 4, then 1:04; running=1; after 20 cycles total, 1:00.
- Run from 1:00 -> after 4 more cycles 0:59 (tens wraps to 5, ones to 9, min to 0).
- Preset 0:02, start -> 0:01 at cycle 4; 0:00 at cycle 8 with done=1 for exactly one cycle and expired=1 held; digits stay 0:00 for 20 further cycles.
- pause at cycle 2 after start, hold 10 cycles, then start -> next decrement 2 cycles after resume (partial second preserved).
- pause and start asserted together in RUN -> state PAUSED; load and start asserted together in EXPIRED -> IDLE with digits 1:05.
- With GAME_TIMER_WARN_EN defined, preset 0:12:
  - warn=0 at 0:10;
  - warn=1 from the 0:09 edge;
  - warn stays 1 in EXPIRED;
  - load -> warn=0.
